// File: rtl/ntt_stage_scheduler_if.sv
// Scheduler <-> host / coefficient RAM / butterfly signal bundle.
// master = scheduler side, slave = host, RAM and butterfly side.
interface ntt_stage_scheduler_if #(
  parameter int N = 256
);
  localparam int AW = $clog2(N);

  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-2:0] zeta_idx;
  logic          bf_valid_in;
  logic          bf_valid_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic [2:0]    layer;
  logic          err;

  modport master (
    input  start, hold, bf_valid_out,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid_in,
           wr_en, wr_addr_a, wr_addr_b, layer, err
  );

  modport slave (
    output start, hold, bf_valid_out,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid_in,
           wr_en, wr_addr_a, wr_addr_b, layer, err
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Forward NTT layer/butterfly issue scheduler. Issues one butterfly pair
// read per cycle, drains each layer before the next (layers are data
// dependent), and carries read addresses down a delay line so write-back
// addresses line up with the butterfly output strobe.
module ntt_stage_scheduler #(
  parameter int N       = 256,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 3
) (
  input  logic                  clk,
  input  logic                  r,
  ntt_stage_scheduler_if.master bus
);
  localparam int AW   = $clog2(N);
  localparam int BW   = AW - 1;           // butterfly index width
  localparam int D    = MEM_LAT + BF_LAT; // issue -> write-back distance
  localparam int LAST = AW - 2;           // index of final layer

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] b_q, b_d, iss_b;
  logic [2:0]    layer_q, layer_d, iss_l;
  logic          busy_q, busy_d, done_q, done_d;
  logic          issue, err_q, err_clr, wr_en;
  logic [AW:0]   out_q, out_nxt;
  logic [BW-1:0] zeta_q;

  // Stage 0 holds the registered read strobe/addresses; stage D is write-back.
  logic [D:0]         vld_pipe;
  logic [D:0][AW-1:0] pa_pipe, pb_pipe;

  logic [AW-1:0] len_w, lo_m, bx, nxt_a, nxt_b;
  logic [BW-1:0] nxt_z;

  assign wr_en   = bus.bf_valid_out & busy_q;
  assign out_nxt = out_q + (AW+1)'(vld_pipe[0]) - (AW+1)'(wr_en);

  // Pair addresses and twiddle index for the butterfly about to issue.
  // a = 2*len*g + o is b with its group bits shifted up by one.
  always_comb begin
    len_w = AW'(N / 2) >> iss_l;
    lo_m  = len_w - AW'(1);
    bx    = {1'b0, iss_b};
    nxt_a = ((bx & ~lo_m) << 1) | (bx & lo_m);
    nxt_b = nxt_a | len_w;
    nxt_z = (BW'(1) << iss_l) | (iss_b >> (BW - int'(iss_l)));
  end

  // Next-state: issue sequencing, layer advance and completion.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    layer_d = layer_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    iss_l   = layer_q;
    iss_b   = b_q;
    err_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          layer_d = '0;
          b_d     = '0;
          err_clr = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!bus.hold) begin
          issue = 1'b1;
          b_d   = b_q + BW'(1);
          if (b_q == BW'(N / 2 - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_nxt == '0) begin
          if (layer_q < 3'(LAST)) begin
            // Next layer starts on the same edge the last write retires.
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            iss_l   = layer_q + 3'd1;
            iss_b   = '0;
            issue   = !bus.hold;
            b_d     = bus.hold ? BW'(0) : BW'(1);
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and outstanding-butterfly counter.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      layer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      layer_q <= layer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= err_clr ? '0 : out_nxt;
    end
  end

  // Issue registers and the strobe/address delay line to write-back.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      vld_pipe <= '0;
      pa_pipe  <= '0;
      pb_pipe  <= '0;
      zeta_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[D-1:0], issue};
      pa_pipe  <= {pa_pipe[D-1:0], issue ? nxt_a : pa_pipe[0]};
      pb_pipe  <= {pb_pipe[D-1:0], issue ? nxt_b : pb_pipe[0]};
      if (issue) zeta_q <= nxt_z;
    end
  end

  // Sticky flag: butterfly output strobe disagrees with our own delayed issue.
  always_ff @(posedge clk or negedge r) begin
    if (!r)                                                err_q <= 1'b0;
    else if (err_clr)                                      err_q <= 1'b0;
    else if (busy_q && (bus.bf_valid_out != vld_pipe[D]))  err_q <= 1'b1;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = vld_pipe[0];
  assign bus.rd_addr_a   = pa_pipe[0];
  assign bus.rd_addr_b   = pb_pipe[0];
  assign bus.zeta_idx    = zeta_q;
  assign bus.bf_valid_in = vld_pipe[MEM_LAT];
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr_a   = pa_pipe[D];
  assign bus.wr_addr_b   = pb_pipe[D];
  assign bus.layer       = layer_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench: coefficient RAM + butterfly model around the scheduler,
// golden Kyber-style NTT in the bench for the data check.
module tb_ntt_stage_scheduler;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  ntt_stage_scheduler_if #(.N(256)) sif ();
  ntt_stage_scheduler #(.N(256), .MEM_LAT(1), .BF_LAT(3)) dut (
    .clk (clk),
    .r   (r),
    .bus (sif)
  );

  // ---------------- RAM + butterfly model ----------------
  int   mem [256];
  int   init_mem [256];
  int   gold [256];
  int   zetas [128];
  logic load;
  int   bf_lat;
  int   ra, rb, rz;
  bit [3:0] pv;
  int   pu [4];
  int   pw [4];

  always_ff @(posedge clk) begin
    if (load) for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    if (sif.rd_en) begin
      ra <= mem[sif.rd_addr_a];
      rb <= mem[sif.rd_addr_b];
      rz <= zetas[sif.zeta_idx];
    end
    pv[0] <= sif.bf_valid_in;
    pu[0] <= (ra + (rz * rb) % Q) % Q;
    pw[0] <= (ra - (rz * rb) % Q + Q) % Q;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pu[i] <= pu[i-1];
      pw[i] <= pw[i-1];
    end
    if (sif.wr_en) begin
      mem[sif.wr_addr_a] <= pu[bf_lat-1];
      mem[sif.wr_addr_b] <= pw[bf_lat-1];
    end
  end
  assign sif.bf_valid_out = pv[bf_lat-1];

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // per-run records
  int first_rd, n_rd, n_wr, first_wr, last_wr, done_k, done_after, busy_after;
  int first_err, err_at1, err_at_done, addr_err, hold_viol, busy_at0, rd_at0, wr_in_rst;
  int la [1024];
  int lb [1024];
  int lz [1024];

  function automatic int brv7(input int x);
    int y = 0;
    for (int i = 0; i < 7; i++) if (x[i]) y |= (1 << (6 - i));
    return y;
  endfunction

  // One transform: pulse start, then watch every cycle until done or budget.
  task automatic run_xfer(input int hold_idx, input int rst_at, input bit spur);
    int idx, hcnt, l, bb, ln, g, ea, eb, ez;
    idx = 0; hcnt = 0;
    first_rd = -1; n_rd = 0; n_wr = 0; first_wr = -1; last_wr = -1; done_k = -1;
    done_after = -1; busy_after = -1; first_err = -1; err_at1 = -1; err_at_done = -1;
    addr_err = 0; hold_viol = 0;
    @(negedge clk); sif.start = 1'b1;
    @(negedge clk); sif.start = 1'b0;
    busy_at0 = int'(sif.busy); rd_at0 = int'(sif.rd_en);
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        r = 1'b0;
        #1;
        return;
      end
      sif.start = spur && (k == 10 || k == 600 || k == 924);
      if (hcnt > 0) begin
        if (sif.rd_en) hold_viol++;
        hcnt--;
        if (hcnt == 0) sif.hold = 1'b0;
      end else if (sif.rd_en) begin
        if (first_rd < 0) first_rd = k;
        n_rd++;
        l = idx / 128; bb = idx % 128; ln = 128 >> l; g = bb / ln;
        ea = 2 * ln * g + bb % ln; eb = ea + ln; ez = (1 << l) + g;
        if (idx >= 896 || int'(sif.rd_addr_a) != ea || int'(sif.rd_addr_b) != eb ||
            int'(sif.zeta_idx) != ez || int'(sif.layer) != l) addr_err++;
        if (idx < 1024) begin
          la[idx] = int'(sif.rd_addr_a);
          lb[idx] = int'(sif.rd_addr_b);
          lz[idx] = int'(sif.zeta_idx);
        end
        if (idx == hold_idx) begin sif.hold = 1'b1; hcnt = 10; end
        idx++;
      end
      if (sif.wr_en) begin
        n_wr++; last_wr = k;
        if (first_wr < 0) first_wr = k;
      end
      if (sif.err && first_err < 0) first_err = k;
      if (k == 1) err_at1 = int'(sif.err);
      if (sif.done) begin
        done_k = k; err_at_done = int'(sif.err); sif.start = 1'b0;
        @(negedge clk);
        done_after = int'(sif.done); busy_after = int'(sif.busy);
        break;
      end
    end
    sif.start = 1'b0; sif.hold = 1'b0;
  endtask

  initial begin
    int p, mism, kk, z, t;
    sif.start = 1'b0; sif.hold = 1'b0; load = 1'b0; bf_lat = 3;
    for (int k = 0; k < 128; k++) begin
      p = 1;
      repeat (brv7(k)) p = (p * 17) % Q;
      zetas[k] = p;
    end
    for (int i = 0; i < 256; i++) init_mem[i] = int'($urandom_range(0, Q - 1));

    // reset state
    #1 r = 1'b0;
    #20;
    chk("rst_busy",  int'(sif.busy),  0);
    chk("rst_done",  int'(sif.done),  0);
    chk("rst_rd_en", int'(sif.rd_en), 0);
    chk("rst_wr_en", int'(sif.wr_en), 0);
    chk("rst_layer", int'(sif.layer), 0);
    chk("rst_err",   int'(sif.err),   0);
    chk("rst_addrs", int'({sif.rd_addr_a, sif.rd_addr_b, sif.wr_addr_a, sif.wr_addr_b}), 0);
    chk("rst_zeta",  int'(sif.zeta_idx), 0);
    @(negedge clk); r = 1'b1;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;

    // golden forward NTT
    for (int i = 0; i < 256; i++) gold[i] = init_mem[i];
    kk = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        z = zetas[kk]; kk++;
        for (int j = st; j < st + len; j++) begin
          t = (z * gold[j + len]) % Q;
          gold[j + len] = (gold[j] - t + Q) % Q;
          gold[j] = (gold[j] + t) % Q;
        end
      end
    end

    // Run 1: nominal transform with stray starts while busy
    run_xfer(-1, -1, 1'b1);
    chk("r1_busy_t0",   busy_at0, 1);
    chk("r1_rd_en_t0",  rd_at0,   0);
    chk("r1_first_rd",  first_rd, 1);
    chk("r1_n_rd",      n_rd,     896);
    chk("r1_first_wr",  first_wr, 5);
    chk("r1_last_wr",   last_wr,  924);
    chk("r1_n_wr",      n_wr,     896);
    chk("r1_done",      done_k,   925);
    chk("r1_done_1cyc", done_after, 0);
    chk("r1_busy_post", busy_after, 0);
    chk("r1_addr_seq",  addr_err, 0);
    chk("r1_err",       err_at_done, 0);
    chk("l0_p0_a", la[0], 0);   chk("l0_p0_b", lb[0], 128); chk("l0_p0_z", lz[0], 1);
    chk("l6_p0_a", la[768], 0); chk("l6_p0_b", lb[768], 2); chk("l6_p0_z", lz[768], 64);
    chk("l6_p1_a", la[769], 1); chk("l6_p1_b", lb[769], 3); chk("l6_p1_z", lz[769], 64);
    chk("l6_p2_a", la[770], 4); chk("l6_p2_b", lb[770], 6); chk("l6_p2_z", lz[770], 65);
    chk("l6_last_a", la[895], 253); chk("l6_last_b", lb[895], 255); chk("l6_last_z", lz[895], 127);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != gold[i]) mism++;
    chk("ntt_coeff_mismatches", mism, 0);

    // Run 2: hold 10 cycles after layer 2 b=49 issues
    run_xfer(2 * 128 + 49, -1, 1'b0);
    chk("r2_hold_rd_en", hold_viol, 0);
    chk("r2_addr_seq",   addr_err,  0);
    chk("r2_n_rd",       n_rd,      896);
    chk("r2_last_wr",    last_wr,   934);
    chk("r2_done",       done_k,    935);

    // Run 3: butterfly one cycle slower than the scheduler expects
    bf_lat = 4;
    run_xfer(-1, -1, 1'b0);
    chk("r3_first_wr",  first_wr,    6);
    chk("r3_first_err", first_err,   6);
    chk("r3_err_done",  err_at_done, 1);
    chk("r3_done",      done_k,      932);
    @(negedge clk);
    chk("r3_err_idle",  int'(sif.err), 1);
    bf_lat = 3;

    // Run 4: reset mid-transform (layer 2)
    run_xfer(-1, 300, 1'b0);
    chk("r4_err_cleared", err_at1, 0);
    chk("r4_rst_busy", int'(sif.busy), 0);
    chk("r4_rst_outs", int'({sif.done, sif.rd_en, sif.bf_valid_in, sif.wr_en, sif.err,
                             sif.layer, sif.zeta_idx}), 0);
    chk("r4_rst_addrs", int'({sif.rd_addr_a, sif.rd_addr_b, sif.wr_addr_a, sif.wr_addr_b}), 0);
    wr_in_rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (sif.wr_en) wr_in_rst++;
    end
    r = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (sif.wr_en) wr_in_rst++;
    end
    chk("r4_no_wr_after_rst", wr_in_rst, 0);
    chk("r4_idle_busy", int'(sif.busy), 0);

    // Run 5: clean transform after the abandoned one
    run_xfer(-1, -1, 1'b0);
    chk("r5_done",     done_k,      925);
    chk("r5_n_wr",     n_wr,        896);
    chk("r5_addr_seq", addr_err,    0);
    chk("r5_err",      err_at_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
